// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: owns the PC, one fetch outstanding, hands {inst, inst_pc} to the IDU.
// Optional: define YSYX_22050039_IFU_MISALIGN_EN for the inst_fault port and misaligned-PC trap.
module ysyx_22050039_ifu #(
  parameter int              XLEN     = 64,
  parameter int              INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [XLEN-1:0]     req_addr,
  input  logic                rsp_valid,
  input  logic [XLEN-1:0]     rsp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     inst_pc,
`ifdef YSYX_22050039_IFU_MISALIGN_EN
  output logic                inst_fault,
`endif
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     w_pc_n;
  logic                r_flush;
  logic                w_flush_n;
  logic [INST_LEN-1:0] r_inst;
  logic [INST_LEN-1:0] w_inst_n;
  logic [XLEN-1:0]     r_inst_pc;
  logic [XLEN-1:0]     w_ipc_n;
  logic                w_ld;
  logic                w_acc;
  logic                w_hs;
`ifdef YSYX_22050039_IFU_MISALIGN_EN
  logic                r_fault;
  logic                w_fault_n;
`endif

  assign req_valid  = (r_state == S_REQ);
  assign req_addr   = {r_pc[XLEN-1:3], 3'b000};
  assign inst_valid = (r_state == S_OUT);
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
`ifdef YSYX_22050039_IFU_MISALIGN_EN
  assign inst_fault = r_fault;
`endif

  assign w_acc = req_valid & req_ready;
  assign w_hs  = inst_valid & inst_ready;

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_flush_n = r_flush;
    w_ld      = 1'b0;
    w_inst_n  = r_inst;
    w_ipc_n   = r_inst_pc;
`ifdef YSYX_22050039_IFU_MISALIGN_EN
    w_fault_n = r_fault;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_state_n = S_REQ;
        if (redirect_valid) w_pc_n = redirect_pc;
      end
      S_REQ: begin
        if (redirect_valid) w_pc_n = redirect_pc;
        if (w_acc) begin
          w_state_n = S_WAIT;
          // beat for the old PC is still coming back
          if (redirect_valid) w_flush_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (r_flush || redirect_valid) begin
            w_state_n = S_REQ;
            w_flush_n = 1'b0;
            if (redirect_valid) w_pc_n = redirect_pc;
          end else begin
            w_state_n = S_OUT;
            w_ld      = 1'b1;
            w_ipc_n   = r_pc;
            w_inst_n  = r_pc[2] ? rsp_data[2*INST_LEN-1:INST_LEN]
                                : rsp_data[INST_LEN-1:0];
          end
        end else if (redirect_valid) begin
          w_pc_n    = redirect_pc;
          w_flush_n = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          w_pc_n    = redirect_pc;
          w_state_n = S_REQ;
        end else if (w_hs) begin
          w_pc_n    = r_pc + XLEN'(4);
          w_state_n = S_REQ;
        end
`ifdef YSYX_22050039_IFU_MISALIGN_EN
        if (redirect_valid || w_hs) w_fault_n = 1'b0;
`endif
      end
      default: w_state_n = S_IDLE;
    endcase
`ifdef YSYX_22050039_IFU_MISALIGN_EN
    // a misaligned PC never reaches the bus; it is reported straight to the IDU
    if (w_state_n == S_REQ && w_pc_n[1:0] != 2'b00) begin
      w_state_n = S_OUT;
      w_fault_n = 1'b1;
      w_ld      = 1'b1;
      w_inst_n  = '0;
      w_ipc_n   = w_pc_n;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_flush   <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= '0;
`ifdef YSYX_22050039_IFU_MISALIGN_EN
      r_fault   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_flush <= w_flush_n;
      if (w_ld) begin
        r_inst    <= w_inst_n;
        r_inst_pc <= w_ipc_n;
      end
`ifdef YSYX_22050039_IFU_MISALIGN_EN
      r_fault <= w_fault_n;
`endif
    end
  end

endmodule
